// File: rtl/mem_cache_controller_pkg.sv
// Shared definitions for the MEM-stage data cache: FSM encodings and line geometry.
package mem_cache_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_MISS = 2'd1,
    ST_WR      = 2'd2
  } state_t;

  localparam int BASE_ADDR_DEF = 1024;
  localparam int LINE_W        = 64;

endpackage

// File: rtl/mem_cache_controller_cache_line_array.sv
// Direct-mapped line storage: valid/tag/two data words per line.
// Asynchronous read by index; synchronous fill, single-word update and valid clear.
module cache_line_array
  import mem_cache_controller_pkg::*;
#(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] idx,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [LINE_W-1:0]  rd_data,
  input  logic               fill_en,
  input  logic [TAG_W-1:0]   fill_tag,
  input  logic [LINE_W-1:0]  fill_data,
  input  logic               word_en,
  input  logic               word_off,
  input  logic [31:0]        word_data
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINE_W-1:0] data_mem [LINES];

  assign rd_valid = valid[idx];
  assign rd_tag   = tag_mem[idx];
  assign rd_data  = data_mem[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (fill_en) begin
      valid[idx] <= 1'b1;
    end
  end

  // Data and tags need no reset: nothing is trusted until its valid bit is set.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[idx]  <= fill_tag;
      data_mem[idx] <= fill_data;
    end else if (word_en) begin
      if (word_off) data_mem[idx][63:32] <= word_data;
      else          data_mem[idx][31:0]  <= word_data;
    end
  end

endmodule

// File: rtl/mem_cache_controller.sv
// MEM-stage direct-mapped, write-through, no-write-allocate data cache in front of an SRAM controller.
// Handshake: sram_req is a registered level held with addr/we/wdata until a one-cycle sram_ready pulse.
module mem_cache_controller
  import mem_cache_controller_pkg::*;
#(
  parameter int BASE_ADDR = BASE_ADDR_DEF,
  parameter int INDEX_W   = 6,
  parameter int ADDR_W    = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_R_EN,
  input  logic              MEM_W_EN,
  input  logic [31:0]       ALU_Res,
  input  logic [31:0]       Val_Rm,
  output logic              ready,
  output logic [31:0]       MEM_Res,
  output logic              sram_req,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [63:0]       sram_rdata,
  input  logic              sram_ready,
  output logic [1:0]        state_dbg
);

  localparam int TAG_W = ADDR_W - INDEX_W - 3;

  state_t state, state_next;

  logic [31:0]        off_addr;
  logic [ADDR_W-1:0]  a;
  logic               off;
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               unused_bits;

  assign off_addr    = ALU_Res - 32'(BASE_ADDR);
  assign a           = off_addr[ADDR_W-1:0];
  assign off         = a[2];
  assign idx         = a[INDEX_W+2:3];
  assign tag         = a[ADDR_W-1:INDEX_W+3];
  assign unused_bits = ^{off_addr[31:ADDR_W], a[1:0]};

  logic               line_valid;
  logic [TAG_W-1:0]   line_tag;
  logic [LINE_W-1:0]  line_data;
  logic               hit;
  logic               is_load;
  logic               fill_en;
  logic               word_en;

  assign hit     = line_valid && (line_tag == tag);
  assign is_load = MEM_R_EN && !MEM_W_EN;

  cache_line_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_lines (
    .clk       (clk),
    .rst       (rst),
    .idx       (idx),
    .rd_valid  (line_valid),
    .rd_tag    (line_tag),
    .rd_data   (line_data),
    .fill_en   (fill_en),
    .fill_tag  (tag),
    .fill_data (sram_rdata),
    .word_en   (word_en),
    .word_off  (off),
    .word_data (Val_Rm)
  );

  // Request fields are captured once on leaving IDLE so they stay stable for the whole transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      sram_req   <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      state    <= state_next;
      sram_req <= (state_next != ST_IDLE);
      if (state == ST_IDLE && state_next != ST_IDLE) begin
        sram_we    <= MEM_W_EN;
        sram_addr  <= MEM_W_EN ? {a[ADDR_W-1:2], 2'b00} : {a[ADDR_W-1:3], 3'b000};
        sram_wdata <= Val_Rm;
      end
    end
  end

  always_comb begin
    state_next = state;
    ready      = 1'b1;
    MEM_Res    = 32'b0;
    fill_en    = 1'b0;
    word_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (MEM_W_EN) begin
          ready      = 1'b0;
          state_next = ST_WR;
        end else if (MEM_R_EN) begin
          if (hit) begin
            MEM_Res = off ? line_data[63:32] : line_data[31:0];
          end else begin
            ready      = 1'b0;
            state_next = ST_RD_MISS;
          end
        end
      end
      ST_RD_MISS: begin
        if (sram_ready) begin
          fill_en    = 1'b1;
          state_next = ST_IDLE;
          if (is_load) MEM_Res = off ? sram_rdata[63:32] : sram_rdata[31:0];
        end else begin
          ready = 1'b0;
        end
      end
      ST_WR: begin
        if (sram_ready) begin
          word_en    = hit;
          state_next = ST_IDLE;
        end else begin
          ready = 1'b0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_mem_cache_controller.sv
// Directed bench for mem_cache_controller: table of load/store vectors plus reset and idle-pulse sequences.
module tb_mem_cache_controller;
  import mem_cache_controller_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MEM_R_EN = 1'b0;
  logic        MEM_W_EN = 1'b0;
  logic [31:0] ALU_Res = 32'd0;
  logic [31:0] Val_Rm = 32'd0;
  logic        ready;
  logic [31:0] MEM_Res;
  logic        sram_req;
  logic        sram_we;
  logic [16:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [63:0] sram_rdata = 64'd0;
  logic        sram_ready = 1'b0;
  logic [1:0]  state_dbg;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [63:0] rline;
    logic        exp_sram;
    logic [16:0] exp_saddr;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs[$];

  mem_cache_controller dut (
    .clk        (clk),
    .rst        (rst),
    .MEM_R_EN   (MEM_R_EN),
    .MEM_W_EN   (MEM_W_EN),
    .ALU_Res    (ALU_Res),
    .Val_Rm     (Val_Rm),
    .ready      (ready),
    .MEM_Res    (MEM_Res),
    .sram_req   (sram_req),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .sram_ready (sram_ready),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    ALU_Res  = 32'd0;
    Val_Rm   = 32'd0;
  endtask

  // Drives one op; SRAM answers two cycles after the request is raised.
  task automatic do_op(input vec_t v);
    @(negedge clk);
    MEM_R_EN = v.r;
    MEM_W_EN = v.w;
    ALU_Res  = v.addr;
    Val_Rm   = v.wdata;
    exp_q.push_back(v.exp_res);
    #1;
    if (!v.exp_sram) begin
      chk("hit_ready", 64'(ready), 64'd1);
      chk("hit_res", 64'(MEM_Res), 64'(exp_q.pop_front()));
      chk("hit_no_req", 64'(sram_req), 64'd0);
      @(posedge clk);
      #1 idle_inputs();
    end else begin
      chk("decide_ready", 64'(ready), 64'd0);
      @(negedge clk);
      chk("req_high", 64'(sram_req), 64'd1);
      chk("req_we", 64'(sram_we), 64'(v.w));
      chk("req_addr", 64'(sram_addr), 64'(v.exp_saddr));
      if (v.w) chk("req_wdata", 64'(sram_wdata), 64'(v.wdata));
      chk("wait_ready", 64'(ready), 64'd0);
      @(negedge clk);
      chk("hold_addr", 64'(sram_addr), 64'(v.exp_saddr));
      sram_rdata = v.rline;
      sram_ready = 1'b1;
      #1;
      chk("done_ready", 64'(ready), 64'd1);
      chk("done_res", 64'(MEM_Res), 64'(exp_q.pop_front()));
      @(posedge clk);
      #1;
      sram_ready = 1'b0;
      sram_rdata = 64'd0;
      idle_inputs();
      @(negedge clk);
      chk("req_dropped", 64'(sram_req), 64'd0);
      chk("back_idle", 64'(state_dbg), 64'(ST_IDLE));
    end
  endtask

  initial begin
    // r, w, addr, wdata, rline, exp_sram, exp_saddr, exp_res
    vecs.push_back('{1'b1, 1'b0, 32'd1024, 32'd0, {32'hB, 32'hA}, 1'b1, 17'd0, 32'hA});
    vecs.push_back('{1'b1, 1'b0, 32'd1028, 32'd0, 64'd0, 1'b0, 17'd0, 32'hB});
    vecs.push_back('{1'b0, 1'b1, 32'd1028, 32'h55, 64'd0, 1'b1, 17'd4, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'd1028, 32'd0, 64'd0, 1'b0, 17'd0, 32'h55});
    vecs.push_back('{1'b0, 1'b1, 32'd1536, 32'h77, 64'd0, 1'b1, 17'd512, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'd1024, 32'd0, 64'd0, 1'b0, 17'd0, 32'hA});
    vecs.push_back('{1'b1, 1'b0, 32'd1536, 32'd0, {32'hD, 32'hC}, 1'b1, 17'd512, 32'hC});
    vecs.push_back('{1'b1, 1'b0, 32'd1024, 32'd0, {32'h55, 32'hA}, 1'b1, 17'd0, 32'hA});
    vecs.push_back('{1'b1, 1'b0, 32'd1524, 32'd0, {32'hE2, 32'hE1}, 1'b1, 17'd496, 32'hE2});
    vecs.push_back('{1'b1, 1'b0, 32'h0002_0000 + 32'd1520, 32'd0, 64'd0, 1'b0, 17'd0, 32'hE1});
    vecs.push_back('{1'b1, 1'b0, 32'd1020, 32'd0, {32'hC2, 32'hC1}, 1'b1, 17'h1FFF8, 32'hC2});
    vecs.push_back('{1'b1, 1'b1, 32'd1040, 32'h99, 64'd0, 1'b1, 17'd16, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 32'd1040, 32'd0, {32'hF2, 32'hF1}, 1'b1, 17'd16, 32'hF1});

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_req", 64'(sram_req), 64'd0);
    chk("rst_res", 64'(MEM_Res), 64'd0);
    chk("rst_state", 64'(state_dbg), 64'(ST_IDLE));

    foreach (vecs[i]) do_op(vecs[i]);

    // A stray sram_ready while idle must not disturb anything.
    @(negedge clk);
    sram_rdata = {32'hDEAD, 32'hBEEF};
    sram_ready = 1'b1;
    #1;
    chk("stray_ready", 64'(ready), 64'd1);
    chk("stray_res", 64'(MEM_Res), 64'd0);
    @(posedge clk);
    #1;
    sram_ready = 1'b0;
    sram_rdata = 64'd0;
    @(negedge clk);
    chk("stray_state", 64'(state_dbg), 64'(ST_IDLE));
    chk("stray_req", 64'(sram_req), 64'd0);
    do_op('{1'b1, 1'b0, 32'd1024, 32'd0, 64'd0, 1'b0, 17'd0, 32'hA});

    // Reset in the middle of a read miss abandons it and invalidates the cache.
    @(negedge clk);
    MEM_R_EN = 1'b1;
    ALU_Res  = 32'd1032;
    @(negedge clk);
    chk("mid_req", 64'(sram_req), 64'd1);
    chk("mid_state", 64'(state_dbg), 64'(ST_RD_MISS));
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_req", 64'(sram_req), 64'd0);
    chk("mid_rst_state", 64'(state_dbg), 64'(ST_IDLE));
    chk("mid_rst_ready", 64'(ready), 64'd1);
    do_op('{1'b1, 1'b0, 32'd1024, 32'd0, {32'h55, 32'hA}, 1'b1, 17'd0, 32'hA});
    do_op('{1'b1, 1'b0, 32'd1028, 32'd0, 64'd0, 1'b0, 17'd0, 32'h55});

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
